hd44780_lcd_responder: RTL and testbench

Synthesizable model of the LCD module side of the 4-bit HD44780-style bus: the receiving end of the lcd_data/lcd_rs/lcd_rw/lcd_en/lcd_on interface that our LCD controllers drive.
- Samples en strobes, assembles nibbles into instructions and data bytes, and maintains DDRAM, the address counter, display flags and a busy timer.
- Answers busy-flag and data reads.
- Exposes observation ports so controller benches can check text and commands without waveform inspection.

---
 rtl/hd44780_lcd_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_hd44780_lcd_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hd44780_lcd_responder.sv
// LCD-module side of the 4-bit HD44780 bus: captures controller strobes, keeps DDRAM,
// address counter, display flags and busy timer, answers reads, and reports executed traffic.
module hd44780_lcd_responder #(
   parameter int BUSY_CYCLES  = 2000,
   parameter int CLEAR_CYCLES = 82000,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] lcd_data,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic       lcd_en,
   input  logic       lcd_on,
   output logic [3:0] lcd_data_out,
   output logic       lcd_data_oe,
   output logic       busy,
   output logic [6:0] cursor_addr,
   output logic       four_bit_mode,
   output logic       two_line_mode,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       cmd_valid,
   output logic [7:0] cmd_code,
   output logic       char_valid,
   output logic [6:0] char_addr,
   output logic [7:0] char_code,
   output logic [7:0] protocol_errors,
   input  logic [6:0] peek_addr,
   output logic [7:0] peek_data,
   output logic       debug_phase
);

   localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic {PH_HIGH = 1'b0, PH_LOW = 1'b1} phase_t;

   phase_t        phase_q, phase_d;
   logic [6:0]    sync_q [SYNC_STAGES];
   logic [6:0]    sync_d;
   logic [7:0]    ddram [128];
   logic [6:0]    ac;
   logic          inc_mode, cgram_sel;
   logic [3:0]    hold_nib;
   logic [CW-1:0] busy_cnt;

   logic          en_s, rs_s, rw_s, en_d, rs_d, rw_d;
   logic [3:0]    data_d;
   logic          fall, rd_stb, rd_step, err_stb, hold_load, exec, long_cmd, clear_stb, rd_low;
   logic [7:0]    exec_byte, rd_byte;
   logic [3:0]    rd_nib;

   // Address-counter step with the one-line / two-line wrap; out-of-range values snap back.
   function automatic logic [6:0] step_ac(input logic [6:0] a, input logic inc, input logic two);
      logic [6:0] r;
      r = a;
      if (two) begin
         if (inc) begin
            if (a < 7'h27 || (a >= 7'h40 && a < 7'h67)) r = a + 7'd1;
            else if (a < 7'h40)                         r = 7'h40;
            else                                        r = 7'h00;
         end else begin
            if (a == 7'h00 || a > 7'h67)      r = 7'h67;
            else if (a <= 7'h27 || a > 7'h40) r = a - 7'd1;
            else                              r = 7'h27;
         end
      end else begin
         if (inc) r = (a >= 7'h4F) ? 7'h00 : a + 7'd1;
         else     r = (a == 7'h00 || a > 7'h4F) ? 7'h4F : a - 7'd1;
      end
      return r;
   endfunction

   // Bus is {en, rs, rw, data}; sync_d lags the last stage so rs/rw/data align with en_d.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         sync_d <= '0;
      end else begin
         sync_q[0] <= {lcd_en, lcd_rs, lcd_rw, lcd_data};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         sync_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign en_s   = sync_q[SYNC_STAGES-1][6];
   assign rs_s   = sync_q[SYNC_STAGES-1][5];
   assign rw_s   = sync_q[SYNC_STAGES-1][4];
   assign en_d   = sync_d[6];
   assign rs_d   = sync_d[5];
   assign rw_d   = sync_d[4];
   assign data_d = sync_d[3:0];
   assign fall   = lcd_on & en_d & ~en_s;
   assign busy   = (busy_cnt != '0);

   always_ff @(posedge clock) begin
      if (reset) phase_q <= PH_HIGH;
      else       phase_q <= phase_d;
   end

   always_comb begin
      phase_d   = phase_q;
      rd_stb    = 1'b0;
      err_stb   = 1'b0;
      hold_load = 1'b0;
      exec      = 1'b0;
      exec_byte = 8'h00;
      if (fall) begin
         if (rw_d) begin
            rd_stb = 1'b1;
            if (four_bit_mode) phase_d = (phase_q == PH_HIGH) ? PH_LOW : PH_HIGH;
         end else if (busy) begin
            err_stb = 1'b1;
         end else if (four_bit_mode && phase_q == PH_HIGH) begin
            hold_load = 1'b1;
            phase_d   = PH_LOW;
         end else begin
            exec      = 1'b1;
            exec_byte = four_bit_mode ? {hold_nib, data_d} : {data_d, 4'h0};
            phase_d   = PH_HIGH;
         end
      end
   end

   assign rd_step   = rd_stb & rs_d & (~four_bit_mode | (phase_q == PH_LOW));
   assign long_cmd  = (exec_byte[7:2] == 6'd0) && (exec_byte[1:0] != 2'd0);
   assign clear_stb = exec & ~rs_d & (exec_byte == 8'h01);

   // cmd_valid/char_valid are single-cycle strobes with no ready: the observer must take
   // cmd_code or char_addr/char_code on the same cycle the strobe is high.
   always_ff @(posedge clock) begin
      if (reset) begin
         ac              <= 7'h00;
         inc_mode        <= 1'b1;
         cgram_sel       <= 1'b0;
         hold_nib        <= 4'h0;
         busy_cnt        <= '0;
         four_bit_mode   <= 1'b0;
         two_line_mode   <= 1'b0;
         display_on      <= 1'b0;
         cursor_on       <= 1'b0;
         blink_on        <= 1'b0;
         cmd_valid       <= 1'b0;
         cmd_code        <= 8'h00;
         char_valid      <= 1'b0;
         char_addr       <= 7'h00;
         char_code       <= 8'h00;
         protocol_errors <= 8'h00;
      end else begin
         cmd_valid  <= 1'b0;
         char_valid <= 1'b0;
         if (busy) busy_cnt <= busy_cnt - CW'(1);
         if (hold_load) hold_nib <= data_d;
         if (err_stb && protocol_errors != 8'hFF) protocol_errors <= protocol_errors + 8'd1;
         if (rd_step) begin
            ac       <= step_ac(ac, inc_mode, two_line_mode);
            busy_cnt <= CW'(BUSY_CYCLES);
         end
         if (exec && !rs_d) begin
            cmd_valid <= 1'b1;
            cmd_code  <= exec_byte;
            busy_cnt  <= long_cmd ? CW'(CLEAR_CYCLES) : CW'(BUSY_CYCLES);
            casez (exec_byte)
               8'b1???????: begin ac <= exec_byte[6:0]; cgram_sel <= 1'b0; end
               8'b01??????: cgram_sel <= 1'b1;
               8'b001?????: begin
                  four_bit_mode <= ~exec_byte[4];
                  two_line_mode <= exec_byte[3];
               end
               8'b0001????: if (!exec_byte[3]) ac <= step_ac(ac, exec_byte[2], two_line_mode);
               8'b00001???: begin
                  display_on <= exec_byte[2];
                  cursor_on  <= exec_byte[1];
                  blink_on   <= exec_byte[0];
               end
               8'b000001??: inc_mode <= exec_byte[1];
               8'b0000001?: begin ac <= 7'h00; cgram_sel <= 1'b0; end
               8'b00000001: begin ac <= 7'h00; inc_mode <= 1'b1; cgram_sel <= 1'b0; end
               default: ;
            endcase
         end
         if (exec && rs_d) begin
            busy_cnt <= CW'(BUSY_CYCLES);
            if (!cgram_sel) begin
               char_valid <= 1'b1;
               char_addr  <= ac;
               char_code  <= exec_byte;
               ac         <= step_ac(ac, inc_mode, two_line_mode);
            end
         end
      end
   end

   // Flop array so reset and clear-display wipe every cell in a single cycle.
   always_ff @(posedge clock) begin
      if (reset || clear_stb) begin
         for (int i = 0; i < 128; i++) ddram[i] <= 8'h20;
      end else if (exec && rs_d && !cgram_sel) begin
         ddram[ac] <= exec_byte;
      end
      peek_data <= ddram[peek_addr];
   end

   assign rd_byte     = ddram[ac];
   assign rd_low      = four_bit_mode & (phase_q == PH_LOW);
   assign lcd_data_oe = lcd_on & en_s & rw_s;

   always_comb begin
      rd_nib = 4'h0;
      if (rs_s) rd_nib = rd_low ? rd_byte[3:0] : rd_byte[7:4];
      else      rd_nib = rd_low ? ac[3:0] : {busy, ac[6:4]};
      lcd_data_out = lcd_data_oe ? rd_nib : 4'h0;
   end

   assign cursor_addr = ac;
   assign debug_phase = (phase_q == PH_LOW);

endmodule

// File: tb/tb_hd44780_lcd_responder.sv
// Directed bench for hd44780_lcd_responder: init sequence, text writes, AC wrap,
// busy rejection, status/data reads and reset mid-transfer.
module tb_hd44780_lcd_responder;

   logic       clock;
   logic       reset;
   logic [3:0] lcd_data;
   logic       lcd_rs, lcd_rw, lcd_en, lcd_on;
   logic [3:0] lcd_data_out;
   logic       lcd_data_oe, busy;
   logic [6:0] cursor_addr;
   logic       four_bit_mode, two_line_mode, display_on, cursor_on, blink_on;
   logic       cmd_valid;
   logic [7:0] cmd_code;
   logic       char_valid;
   logic [6:0] char_addr;
   logic [7:0] char_code;
   logic [7:0] protocol_errors;
   logic [6:0] peek_addr;
   logic [7:0] peek_data;
   logic       debug_phase;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  cmd_exp_q[$];
   logic [14:0] char_exp_q[$];

   logic [3:0] rd_nib;
   logic       rd_oe;

   hd44780_lcd_responder #(
      .BUSY_CYCLES(4),
      .CLEAR_CYCLES(8),
      .SYNC_STAGES(2)
   ) dut (
      .clock(clock), .reset(reset),
      .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on),
      .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe), .busy(busy),
      .cursor_addr(cursor_addr), .four_bit_mode(four_bit_mode), .two_line_mode(two_line_mode),
      .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
      .cmd_valid(cmd_valid), .cmd_code(cmd_code),
      .char_valid(char_valid), .char_addr(char_addr), .char_code(char_code),
      .protocol_errors(protocol_errors), .peek_addr(peek_addr), .peek_data(peek_data),
      .debug_phase(debug_phase)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every pulse must match the head of its expected queue
   always @(negedge clock) begin
      if (!reset && cmd_valid) begin
         logic [8:0] e;
         e = (cmd_exp_q.size() != 0) ? {1'b0, cmd_exp_q.pop_front()} : 9'h1FF;
         check("cmd_code", {23'd0, 1'b0, cmd_code}, {23'd0, e});
      end
      if (!reset && char_valid) begin
         logic [15:0] e;
         e = (char_exp_q.size() != 0) ? {1'b0, char_exp_q.pop_front()} : 16'hFFFF;
         check("char_addr_code", {16'd0, 1'b0, char_addr, char_code}, {16'd0, e});
      end
   end

   // driver tasks
   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic strobe(input logic rs, input logic [3:0] d);
      @(negedge clock);
      lcd_rs = rs; lcd_rw = 1'b0; lcd_data = d; lcd_en = 1'b1;
      repeat (2) @(negedge clock);
      lcd_en = 1'b0;
   endtask

   task automatic wbyte(input logic rs, input logic [7:0] b);
      strobe(rs, b[7:4]);
      idle(1);
      strobe(rs, b[3:0]);
   endtask

   task automatic do_read(input logic rs, output logic [3:0] nib, output logic oe);
      @(negedge clock);
      lcd_rs = rs; lcd_rw = 1'b1; lcd_data = 4'h0; lcd_en = 1'b1;
      repeat (2) @(negedge clock);
      nib = lcd_data_out;
      oe  = lcd_data_oe;
      @(negedge clock);
      lcd_en = 1'b0;
   endtask

   task automatic peek(input string tag, input logic [6:0] a, input logic [7:0] exp);
      @(negedge clock);
      peek_addr = a;
      @(negedge clock);
      check(tag, {24'd0, peek_data}, {24'd0, exp});
   endtask

   initial begin
      reset = 1'b1; lcd_data = 4'h0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_en = 1'b0;
      lcd_on = 1'b1; peek_addr = 7'h00;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // reset state
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_ac", {25'd0, cursor_addr}, 0);
      check("rst_four_bit", {31'd0, four_bit_mode}, 0);
      check("rst_two_line", {31'd0, two_line_mode}, 0);
      check("rst_flags", {29'd0, display_on, cursor_on, blink_on}, 0);
      check("rst_pulses", {30'd0, cmd_valid, char_valid}, 0);
      check("rst_errors", {24'd0, protocol_errors}, 0);
      check("rst_oe_out", {27'd0, lcd_data_oe, lcd_data_out}, 0);
      check("rst_phase", {31'd0, debug_phase}, 0);
      peek("rst_ddram", 7'h05, 8'h20);

      // init: three 0x3 strobes, one 0x2, then 0x28 as two nibbles
      cmd_exp_q.push_back(8'h30);
      strobe(1'b0, 4'h3);
      @(negedge clock);
      @(negedge clock);
      check("latency_early", {31'd0, cmd_valid}, 0);
      @(negedge clock);
      check("latency_hit", {31'd0, cmd_valid}, 1);
      idle(8);
      cmd_exp_q.push_back(8'h30); strobe(1'b0, 4'h3); idle(8);
      cmd_exp_q.push_back(8'h30); strobe(1'b0, 4'h3); idle(8);
      cmd_exp_q.push_back(8'h20); strobe(1'b0, 4'h2); idle(8);
      check("init_four_bit", {31'd0, four_bit_mode}, 1);
      cmd_exp_q.push_back(8'h28); wbyte(1'b0, 8'h28); idle(8);
      check("init_two_line", {31'd0, two_line_mode}, 1);
      check("init_errors", {24'd0, protocol_errors}, 0);

      // display on, entry increment, clear, then "HI"
      cmd_exp_q.push_back(8'h0C); wbyte(1'b0, 8'h0C); idle(8);
      cmd_exp_q.push_back(8'h06); wbyte(1'b0, 8'h06); idle(8);
      cmd_exp_q.push_back(8'h01); wbyte(1'b0, 8'h01); idle(12);
      check("disp_flags", {29'd0, display_on, cursor_on, blink_on}, 32'h4);
      check("clear_ac", {25'd0, cursor_addr}, 0);
      char_exp_q.push_back({7'h00, 8'h48}); wbyte(1'b1, 8'h48); idle(8);
      char_exp_q.push_back({7'h01, 8'h49}); wbyte(1'b1, 8'h49); idle(8);
      check("hi_ac", {25'd0, cursor_addr}, 32'h02);
      peek("peek_h", 7'h00, 8'h48);
      peek("peek_i", 7'h01, 8'h49);
      peek("peek_blank", 7'h02, 8'h20);

      // line-1 end wraps to 0x40; decrement from 0x40 wraps to 0x27
      cmd_exp_q.push_back(8'hA7); wbyte(1'b0, 8'hA7); idle(8);
      check("set_ac_27", {25'd0, cursor_addr}, 32'h27);
      char_exp_q.push_back({7'h27, 8'h41}); wbyte(1'b1, 8'h41); idle(8);
      check("wrap_to_40", {25'd0, cursor_addr}, 32'h40);
      char_exp_q.push_back({7'h40, 8'h42}); wbyte(1'b1, 8'h42); idle(8);
      check("ac_41", {25'd0, cursor_addr}, 32'h41);
      peek("peek_b", 7'h40, 8'h42);
      cmd_exp_q.push_back(8'h04); wbyte(1'b0, 8'h04); idle(8);
      cmd_exp_q.push_back(8'hC0); wbyte(1'b0, 8'hC0); idle(8);
      char_exp_q.push_back({7'h40, 8'h43}); wbyte(1'b1, 8'h43); idle(8);
      check("dec_wrap_27", {25'd0, cursor_addr}, 32'h27);

      // write strobe right behind a command lands while busy
      cmd_exp_q.push_back(8'h80); wbyte(1'b0, 8'h80);
      strobe(1'b1, 4'h5);
      idle(8);
      check("busy_errors", {24'd0, protocol_errors}, 1);
      check("busy_phase", {31'd0, debug_phase}, 0);
      check("busy_ac", {25'd0, cursor_addr}, 0);
      peek("busy_ddram", 7'h00, 8'h48);

      // status read straight after clear shows BF, then clears
      cmd_exp_q.push_back(8'h01); wbyte(1'b0, 8'h01);
      do_read(1'b0, rd_nib, rd_oe);
      check("stat_oe", {31'd0, rd_oe}, 1);
      check("stat_hi_busy", {28'd0, rd_nib}, 32'h8);
      idle(1);
      do_read(1'b0, rd_nib, rd_oe);
      check("stat_lo_busy", {28'd0, rd_nib}, 32'h0);
      idle(10);
      check("busy_cleared", {31'd0, busy}, 0);
      do_read(1'b0, rd_nib, rd_oe);
      check("stat_hi_idle", {28'd0, rd_nib}, 32'h0);
      idle(1);
      do_read(1'b0, rd_nib, rd_oe);
      idle(1);
      do_read(1'b1, rd_nib, rd_oe);
      check("data_hi", {28'd0, rd_nib}, 32'h2);
      idle(1);
      do_read(1'b1, rd_nib, rd_oe);
      check("data_lo", {28'd0, rd_nib}, 32'h0);
      idle(8);
      check("read_ac_step", {25'd0, cursor_addr}, 32'h01);
      check("read_oe_off", {31'd0, lcd_data_oe}, 0);

      // reset after a lone high nibble
      strobe(1'b1, 4'h4);
      idle(4);
      check("half_phase", {31'd0, debug_phase}, 1);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      @(negedge clock);
      check("rst2_four_bit", {31'd0, four_bit_mode}, 0);
      check("rst2_two_line", {31'd0, two_line_mode}, 0);
      check("rst2_ac", {25'd0, cursor_addr}, 0);
      check("rst2_flags", {29'd0, display_on, cursor_on, blink_on}, 0);
      check("rst2_errors", {24'd0, protocol_errors}, 0);
      check("rst2_phase_busy", {30'd0, debug_phase, busy}, 0);
      peek("rst2_ddram", 7'h00, 8'h20);
      cmd_exp_q.push_back(8'hC0); strobe(1'b0, 4'hC); idle(8);
      check("rst2_8bit_ac", {25'd0, cursor_addr}, 32'h40);

      // power off: strobes ignored
      lcd_on = 1'b0;
      strobe(1'b0, 4'h8); idle(8);
      check("off_ac", {25'd0, cursor_addr}, 32'h40);
      do_read(1'b0, rd_nib, rd_oe);
      check("off_oe", {31'd0, rd_oe}, 0);
      lcd_on = 1'b1;
      idle(8);

      check("cmd_q_drained", cmd_exp_q.size(), 0);
      check("char_q_drained", char_exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
